// File: rtl/sram_fetch_ctrl_pkg.sv
// Shared fetch types: region sizes, controller states, in-flight tag.
// Imported by the fetch controller and the SRAM buffer stage.
package sram_pkg;

  localparam int IMG_WORDS = 64;
  localparam int WGT_WORDS = 1024;

  typedef enum logic [2:0] {
    IDLE,
    RD_IMG,
    RD_WGT,
    DRAIN,
    DONE
  } fetch_state_t;

  typedef struct packed {
    logic       valid;
    logic       is_wgt;
    logic [9:0] idx;
  } fetch_tag_t;

endpackage

// File: rtl/sram_fetch_ctrl_if.sv
// SRAM read port plus the tagged word stream toward the buffer.
// master = fetch controller, slave = SRAM model / buffer side.
interface sram_fetch_if #(
  parameter int ADDR_W = 16
);
  logic              sram_ren;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_rdata;
  logic              out_valid;
  logic [15:0]       out_data;
  logic [9:0]        out_idx;
  logic              out_is_wgt;

  modport master (
    output sram_ren,
    output sram_addr,
    input  sram_rdata,
    output out_valid,
    output out_data,
    output out_idx,
    output out_is_wgt
  );

  modport slave (
    input  sram_ren,
    input  sram_addr,
    output sram_rdata,
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_is_wgt
  );
endinterface

// File: rtl/sram_fetch_ctrl_tag_pipe.sv
// Delay line that carries issue tags alongside the SRAM read latency.
// empty_o tells the controller no read is still in flight.
module sram_tag_pipe
  import sram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  fetch_tag_t tag_i,
  output fetch_tag_t tail_o,
  output logic       empty_o
);

  fetch_tag_t pipe_q [DEPTH];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_q[i].valid) empty_o = 1'b0;
    end
  end

  assign tail_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sram_fetch_ctrl.sv
// Streams the image then the weight set out of SRAM, one read
// per cycle, tagging each returned word with region and index.
module sram_fetch_ctrl
  import sram_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] IMG_BASE = '0,
  parameter logic [ADDR_W-1:0] WGT_BASE = ADDR_W'(64),
  parameter int              RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start_sram,
  sram_fetch_if.master bus,
  output logic        sram_done,
  output logic        busy
);

  fetch_state_t state_q, state_d;
  logic [9:0]   cnt_q, cnt_d;
  fetch_tag_t   tag_in, tail;
  logic         pipe_empty;
  logic         issue;
  logic         in_wgt;

  logic         out_valid_q;
  logic         out_is_wgt_q;
  logic [9:0]   out_idx_q;
  logic [15:0]  out_data_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_sram) begin
          state_d = RD_IMG;
          cnt_d   = '0;
        end
      end
      RD_IMG: begin
        if (cnt_q == 10'(IMG_WORDS - 1)) begin
          state_d = RD_WGT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      RD_WGT: begin
        if (cnt_q == 10'(WGT_WORDS - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      DRAIN: begin
        if (pipe_empty) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_wgt = (state_q == RD_WGT);
  assign issue  = (state_q == RD_IMG) || in_wgt;

  // Address is forced to zero whenever no read is issued.
  always_comb begin
    bus.sram_ren  = issue;
    bus.sram_addr = '0;
    if (issue) begin
      bus.sram_addr = (in_wgt ? WGT_BASE : IMG_BASE)
                    + ADDR_W'(cnt_q);
    end
  end

  always_comb begin
    tag_in = '0;
    if (issue) begin
      tag_in.valid  = 1'b1;
      tag_in.is_wgt = in_wgt;
      tag_in.idx    = cnt_q;
    end
  end

  sram_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .n_rst   (n_rst),
    .tag_i   (tag_in),
    .tail_o  (tail),
    .empty_o (pipe_empty)
  );

  // Tail tag lines up with sram_rdata; both are registered together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid_q  <= 1'b0;
      out_is_wgt_q <= 1'b0;
      out_idx_q    <= '0;
      out_data_q   <= '0;
    end else begin
      out_valid_q  <= tail.valid;
      out_is_wgt_q <= tail.is_wgt;
      out_idx_q    <= tail.idx;
      out_data_q   <= tail.valid ? bus.sram_rdata : 16'h0000;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_is_wgt = out_is_wgt_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.out_data   = out_data_q;

  assign sram_done = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_fetch_ctrl.sv
// Directed bench: three controllers (lat 2/1/4) against SRAM models
// returning addr^A5A5, checked cycle by cycle against a timing model.
module tb_sram_fetch_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [2:0] start;
  logic [2:0] go;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_addr(
      input logic [15:0] ib, input int k);
    if (k < 64) return ib + 16'(k);
    return 16'h0040 + 16'(k - 64);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    localparam logic [15:0] B = (g == 0) ? 16'h0000 : 16'hFFF0;

    sram_fetch_if #(.ADDR_W(16)) bus ();
    logic        done_w;
    logic        busy_w;
    logic [15:0] sq [L];

    sram_fetch_ctrl #(
      .ADDR_W   (16),
      .IMG_BASE (B),
      .WGT_BASE (16'h0040),
      .RD_LAT   (L)
    ) u_dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .start_sram (start[g]),
      .bus        (bus),
      .sram_done  (done_w),
      .busy       (busy_w)
    );

    always @(posedge clk) begin
      sq[0] <= bus.sram_ren ? (bus.sram_addr ^ 16'hA5A5)
                            : 16'hBAD0;
      for (int i = 1; i < L; i++) sq[i] <= sq[i-1];
    end
    assign bus.sram_rdata = sq[L-1];

    int t0 = 0;
    bit active = 1'b0;

    always @(negedge clk) begin : mon
      int rel;
      int k;
      bit er, ev, ed, eb;
      rel = cyc - t0;
      er = active && rel >= 1 && rel <= 1088;
      ev = active && rel >= L + 2 && rel <= L + 1089;
      ed = active && rel == L + 1090;
      eb = active && rel >= 1 && rel <= L + 1090;
      if (!n_rst) begin
        check($sformatf("d%0d.rst", g),
              64'({bus.sram_ren, bus.sram_addr, bus.out_valid,
                   bus.out_is_wgt, bus.out_idx, bus.out_data,
                   done_w, busy_w}), 64'd0);
        active <= 1'b0;
      end else if (go[g]) begin
        check($sformatf("d%0d.idle", g), 64'(busy_w), 64'd0);
        t0     <= cyc;
        active <= 1'b1;
      end else begin
        check($sformatf("d%0d.ren", g),
              64'(bus.sram_ren), 64'(er));
        check($sformatf("d%0d.valid", g),
              64'(bus.out_valid), 64'(ev));
        check($sformatf("d%0d.done", g), 64'(done_w), 64'(ed));
        check($sformatf("d%0d.busy", g), 64'(busy_w), 64'(eb));
        if (er) begin
          check($sformatf("d%0d.addr", g),
                64'(bus.sram_addr), 64'(exp_addr(B, rel - 1)));
        end
        if (ev) begin
          k = rel - L - 2;
          check($sformatf("d%0d.wgt", g),
                64'(bus.out_is_wgt), 64'(k >= 64));
          check($sformatf("d%0d.idx", g), 64'(bus.out_idx),
                64'((k < 64) ? k : k - 64));
          check($sformatf("d%0d.data", g), 64'(bus.out_data),
                64'(exp_addr(B, k) ^ 16'hA5A5));
        end
        if (active && rel > L + 1092) active <= 1'b0;
      end
    end
  end

  initial begin
    n_rst = 1'b0;
    start = '0;
    go    = '0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk);
    #1 start = 3'b111;
    go = 3'b111;
    @(posedge clk);
    #1 start = '0;
    go = '0;
    repeat (9) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (1081) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1 start[0] = 1'b1;
    go[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    go[0] = 1'b0;
    repeat (499) @(posedge clk);
    #1 n_rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 start[0] = 1'b1;
    go[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    go[0] = 1'b0;
    repeat (1110) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
